// File: rtl/dff_pipe_if.sv
// Producer/consumer handshake bundle for dff_pipe: valid/ready/data on each side.
interface dff_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Environment side: drives the producer word and the consumer's ready.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Pipe side: accepts producer words and presents them to the consumer.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dff_pipe.sv
// Elastic register pipeline: DEPTH valid/ready stages with bubble collapsing,
// synchronous flush and a registered occupancy count.
module dff_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    dff_pipe_if.slave                    bus,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;        // per-stage valid
    logic [WIDTH-1:0] d [DEPTH]; // per-stage data, stage DEPTH-1 drives the output
    logic [DEPTH-1:0] mv;       // stage hands its word on this cycle
    logic [DEPTH-1:0] ld;       // stage captures a new word this cycle
    logic [DEPTH-1:0] v_nxt;
    logic [OCC_W-1:0] occ_nxt;
    logic             in_fire;

    // Move chain from the output back to stage 0; a stage may advance into an
    // empty successor even while the consumer stalls, so bubbles collapse.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        mv = '0;
        mv[DEPTH-1] = v[DEPTH-1] & bus.out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            mv[i] = v[i] & (~v[i+1] | mv[i+1]);
        end
    end

    assign bus.in_ready  = (~v[0] | mv[0]) & ~flush & ~rst;
    assign in_fire       = bus.in_valid & bus.in_ready;
    assign bus.out_valid = v[DEPTH-1] & ~flush;
    assign bus.out_data  = d[DEPTH-1];

    // Next valid vector, per-stage load enables and the resulting population count.
    always_comb begin
        ld      = '0;
        v_nxt   = v;
        occ_nxt = '0;
        ld[0]   = in_fire;
        for (int i = 1; i < DEPTH; i++) begin
            ld[i] = mv[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (ld[i]) begin
                v_nxt[i] = 1'b1;
            end else if (mv[i]) begin
                v_nxt[i] = 1'b0;
            end
            occ_nxt = occ_nxt + OCC_W'(v_nxt[i]);
        end
    end

    // Stage registers: reset beats flush beats normal movement; data only changes on a load.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
        if (rst) begin
            v         <= '0;
            occupancy <= '0;
            // NOTE: the data registers are reset too, because RESET_VAL is visible on out_data right after reset.
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= RESET_VAL;
            end
        end else if (flush) begin
            v         <= '0;
            occupancy <= '0;
        end else begin
            v         <= v_nxt;
            occupancy <= occ_nxt;
            if (ld[0]) begin
                d[0] <= bus.in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (ld[i]) begin
                    d[i] <= d[i-1];
                end
            end
        end
    end

    // A producer stalled by a full pipe must keep offering the same word.
    property p_stalled_word_held;
        @(posedge clk) disable iff (rst)
            (bus.in_valid && !bus.in_ready && !flush) |=> (bus.in_valid && $stable(bus.in_data));
    endproperty
    a_stalled_word_held: assert property (p_stalled_word_held);
endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: directed tests on an 8x4 pipe plus randomized traffic on
// 1x1 and 32x8 pipes, all checked by a FIFO scoreboard per instance.
module tb_dff_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fl0 = 1'b0;
    logic fl1 = 1'b0;
    logic fl2 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int pops0    = 0;
    int pops1    = 0;
    int pops2    = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    logic [2:0] occ0;
    logic [0:0] occ1;
    logic [3:0] occ2;

    always #5 clk = ~clk;

    dff_pipe_if #(.WIDTH(8))  b0();
    dff_pipe_if #(.WIDTH(1))  b1();
    dff_pipe_if #(.WIDTH(32)) b2();

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u0 (
        .clk(clk), .rst(rst), .flush(fl0), .bus(b0), .occupancy(occ0)
    );
    dff_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b1)) u1 (
        .clk(clk), .rst(rst), .flush(fl1), .bus(b1), .occupancy(occ1)
    );
    dff_pipe #(.WIDTH(32), .DEPTH(8), .RESET_VAL(32'hDEAD_BEEF)) u2 (
        .clk(clk), .rst(rst), .flush(fl2), .bus(b2), .occupancy(occ2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for u0: expected words are queued on acceptance and popped on delivery.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
        end else if (fl0) begin
            check("flush_in_ready0", 64'(b0.in_ready), 64'(0));
            check("flush_out_valid0", 64'(b0.out_valid), 64'(0));
            q0.delete();
        end else begin
            check("occupancy0", 64'(occ0), 64'(q0.size()));
            check("out_valid_empty0", 64'(b0.out_valid && q0.size() == 0), 64'(0));
            if (b0.out_valid && b0.out_ready && q0.size() != 0) begin
                check("out_data0", 64'(b0.out_data), 64'(q0.pop_front()));
                pops0++;
            end
            if (b0.in_valid && b0.in_ready) q0.push_back(32'(b0.in_data));
        end
    end

    // Scoreboard for u1 (1-bit, single stage).
    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
        end else if (fl1) begin
            check("flush_in_ready1", 64'(b1.in_ready), 64'(0));
            check("flush_out_valid1", 64'(b1.out_valid), 64'(0));
            q1.delete();
        end else begin
            check("occupancy1", 64'(occ1), 64'(q1.size()));
            check("out_valid_empty1", 64'(b1.out_valid && q1.size() == 0), 64'(0));
            if (b1.out_valid && b1.out_ready && q1.size() != 0) begin
                check("out_data1", 64'(b1.out_data), 64'(q1.pop_front()));
                pops1++;
            end
            if (b1.in_valid && b1.in_ready) q1.push_back(32'(b1.in_data));
        end
    end

    // Scoreboard for u2 (32-bit, eight stages).
    always @(negedge clk) begin
        if (rst) begin
            q2.delete();
        end else if (fl2) begin
            check("flush_in_ready2", 64'(b2.in_ready), 64'(0));
            check("flush_out_valid2", 64'(b2.out_valid), 64'(0));
            q2.delete();
        end else begin
            check("occupancy2", 64'(occ2), 64'(q2.size()));
            check("out_valid_empty2", 64'(b2.out_valid && q2.size() == 0), 64'(0));
            if (b2.out_valid && b2.out_ready && q2.size() != 0) begin
                check("out_data2", 64'(b2.out_data), 64'(q2.pop_front()));
                pops2++;
            end
            if (b2.in_valid && b2.in_ready) q2.push_back(b2.in_data);
        end
    end

    // Offer one word to u0 and hold it until accepted (bounded).
    task automatic send0(input logic [7:0] data);
        logic acc;
        acc = 1'b0;
        b0.in_valid = 1'b1;
        b0.in_data  = data;
        for (int k = 0; k < 16 && !acc; k++) begin
            @(negedge clk);
            acc = b0.in_ready;
            tick();
        end
        b0.in_valid = 1'b0;
        check("send_accepted", 64'(acc), 64'(1));
    endtask

    // Send one word into an empty u0 and count cycles until it is presented.
    task automatic measure(input logic [7:0] data);
        int n;
        b0.out_ready = 1'b1;
        b0.in_valid  = 1'b1;
        b0.in_data   = data;
        @(negedge clk);
        check("lat_in_ready", 64'(b0.in_ready), 64'(1));
        tick();
        b0.in_valid = 1'b0;
        n = 1;
        @(negedge clk);
        check("lat_occ_1", 64'(occ0), 64'(1));
        while (!b0.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("lat_cycles", 64'(n), 64'(4));
        check("lat_data", 64'(b0.out_data), 64'(data));
        tick();
        check("lat_occ_0", 64'(occ0), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first, last, outs, stalls, blk, p;
        logic acc;

        b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
        b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b0;
        void'($urandom(32'd2024));

        // Reset held for 10 cycles, then a single word's latency.
        repeat (5) tick();
        @(negedge clk);
        check("rst_out_valid", 64'(b0.out_valid), 64'(0));
        check("rst_out_data", 64'(b0.out_data), 64'(8'h00));
        check("rst_in_ready", 64'(b0.in_ready), 64'(0));
        check("rst_out_data1", 64'(b1.out_data), 64'(1));
        check("rst_out_data2", 64'(b2.out_data), 64'(32'hDEAD_BEEF));
        repeat (5) tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(b0.in_ready), 64'(1));
        check("post_rst_occ", 64'(occ0), 64'(0));
        tick();
        measure(8'hA5);

        // Back-to-back streaming at one word per cycle.
        b0.out_ready = 1'b1;
        first = -1; last = -1; outs = 0; stalls = 0;
        for (int i = 0; i < 40; i++) begin
            b0.in_valid = (i < 16);
            b0.in_data  = 8'(i + 1);
            @(negedge clk);
            if (i < 16 && !b0.in_ready) stalls++;
            if (i == 8) check("stream_occ", 64'(occ0), 64'(4));
            if (b0.out_valid) begin
                if (first < 0) first = i;
                last = i;
                outs++;
            end
            tick();
        end
        b0.in_valid = 1'b0;
        check("stream_stalls", 64'(stalls), 64'(0));
        check("stream_outs", 64'(outs), 64'(16));
        check("stream_span", 64'(last - first), 64'(15));

        // Backpressure with a bubble that collapses while the output stalls.
        b0.out_ready = 1'b0;
        p = pops0;
        send0(8'h11);
        tick();
        tick();
        send0(8'h22);
        send0(8'h33);
        send0(8'h44);
        b0.in_valid = 1'b1;
        b0.in_data  = 8'h55;
        blk = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (!b0.in_ready) blk++;
            if (k == 0) check("bp_full_occ", 64'(occ0), 64'(4));
            tick();
        end
        check("bp_blocked", 64'(blk), 64'(3));
        b0.out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) begin
            @(negedge clk);
            acc = b0.in_ready;
            tick();
        end
        b0.in_valid = 1'b0;
        check("bp_55_accepted", 64'(acc), 64'(1));
        for (int k = 0; k < 20 && occ0 != 0; k++) tick();
        check("bp_drained", 64'(occ0), 64'(0));
        check("bp_outputs", 64'(pops0 - p), 64'(5));

        // Flush with three words inside and the producer still offering.
        b0.out_ready = 1'b0;
        send0(8'hC1);
        send0(8'hC2);
        send0(8'hC3);
        tick();
        @(negedge clk);
        check("pre_flush_out_valid", 64'(b0.out_valid), 64'(1));
        tick();
        p = pops0;
        fl0 = 1'b1;
        b0.in_valid = 1'b1;
        b0.in_data  = 8'h99;
        @(negedge clk);
        check("flush_in_ready", 64'(b0.in_ready), 64'(0));
        check("flush_out_valid", 64'(b0.out_valid), 64'(0));
        tick();
        fl0 = 1'b0;
        b0.in_valid = 1'b0;
        @(negedge clk);
        check("post_flush_occ", 64'(occ0), 64'(0));
        check("post_flush_out_valid", 64'(b0.out_valid), 64'(0));
        tick();
        b0.out_ready = 1'b1;
        repeat (8) tick();
        check("flush_no_output", 64'(pops0 - p), 64'(0));

        // Reset while four words are in flight.
        b0.out_ready = 1'b0;
        send0(8'hD1);
        send0(8'hD2);
        send0(8'hD3);
        send0(8'hD4);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 64'(b0.in_ready), 64'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_occ", 64'(occ0), 64'(0));
        check("mid_rst_out_data", 64'(b0.out_data), 64'(8'h00));
        check("mid_rst_out_valid", 64'(b0.out_valid), 64'(0));
        tick();
        measure(8'h7E);

        // Randomized valid/ready/flush traffic on the 1x1 and 32x8 pipes.
        fork
            begin : drive1
                logic pend1;
                pend1 = 1'b0;
                for (int c = 0; c < 2000; c++) begin
                    if (!pend1) begin
                        b1.in_valid = ($urandom_range(0, 1) == 1);
                        b1.in_data  = 1'($urandom_range(0, 1));
                    end
                    b1.out_ready = ($urandom_range(0, 2) != 0);
                    fl1 = ($urandom_range(0, 63) == 0);
                    @(negedge clk);
                    pend1 = b1.in_valid && !b1.in_ready;
                    tick();
                end
                b1.in_valid = 1'b0; fl1 = 1'b0; b1.out_ready = 1'b1;
            end
            begin : drive2
                logic pend2;
                pend2 = 1'b0;
                for (int c = 0; c < 2000; c++) begin
                    if (!pend2) begin
                        b2.in_valid = ($urandom_range(0, 3) != 0);
                        b2.in_data  = $urandom;
                    end
                    b2.out_ready = ($urandom_range(0, 99) < ((c % 400) < 200 ? 25 : 85));
                    fl2 = ($urandom_range(0, 255) == 0);
                    @(negedge clk);
                    pend2 = b2.in_valid && !b2.in_ready;
                    tick();
                end
                b2.in_valid = 1'b0; fl2 = 1'b0; b2.out_ready = 1'b1;
            end
        join
        repeat (20) tick();
        check("sweep_drain1", 64'(q1.size()), 64'(0));
        check("sweep_drain2", 64'(q2.size()), 64'(0));
        check("sweep_traffic1", 64'(pops1 > 200), 64'(1));
        check("sweep_traffic2", 64'(pops2 > 200), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
